uart_frame_rx_module: RTL and testbench
=======================================

Name: uart_frame_rx_module

Overview:
Parametrised successor of the serial receive path. It oversamples an asynchronous UART line, assembles BYTES_PER_FRAME characters of DATA_BITS each into one frame word, and checks optional parity and the stop bit. It tracks bus idle, aborts frames on inter-byte timeout, and detects collisions against the local transmitter's loopback bit. It sits between the pin and the frame-level control logic, which consumes Rx_Data on Rx_Done_Sig.

Parameters:
CLKS_PER_BIT, 434, CLK cycles per bit (minimum 8).
DATA_BITS, 8, data bits per character (5..9).
BYTES_PER_FRAME, 4, characters per frame (1..8).
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
IDLE_BITS, 11, bit times of continuous high that define bus idle and inter-byte timeout.

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
Rx_Pin_In  in  1  asynchronous serial line, idle high
Rx_En_Sig  in  1  receive enable, level
Tx_Active  in  1  local transmitter is driving the line
Tx_Pin_Loopback  in  1  bit the local transmitter is currently driving
Rx_Data  out  DATA_BITS*BYTES_PER_FRAME  last complete frame
Rx_Done_Sig  out  1  one-cycle pulse, frame valid
Rx_Err_Sig  out  1  one-cycle pulse: framing, parity or timeout error
Tx_Cancel  out  1  one-cycle pulse: collision detected
Start_Rx  out  1  one-cycle pulse: first start bit of a frame validated
Bus_Idle  out  1  level: line high for at least IDLE_BITS bit times

Behaviour:
- Reset: all outputs 0 (Rx_Data all zeros, Bus_Idle 0), state IDLE, all counters 0. Reset mid-frame discards the partial frame; no pulses are generated.
- Input path: Rx_Pin_In passes through a 2-flop synchroniser. A falling edge is detected on the synchronised value.
- Sampling: the bit counter runs 0..CLKS_PER_BIT-1. The bit value is the majority of the samples at counts C/2-1, C/2 and C/2+1, where C=CLKS_PER_BIT. The decision is registered at C/2+1.
- States: IDLE, START, DATA, PARITY, STOP, GAP, BREAK.
- IDLE: on a falling edge with Rx_En_Sig=1, go to START. No edges are accepted while Rx_En_Sig=0.
- START: if the majority sample is 1, treat it as a false start and return to IDLE (or GAP if mid-frame) with no pulse. If it is 0, go to DATA. Start_Rx pulses at that point only when the byte index is 0.
- DATA: DATA_BITS samples, LSB first. Then go to PARITY if PARITY_EN=1, otherwise STOP.
- PARITY: compare the sample with the XOR of the data bits, inverted when PARITY_ODD=1. A mismatch is flagged for the STOP decision.
- STOP: a sample of 0 is a framing error. On a framing error, pulse Rx_Err_Sig, discard the frame and go to BREAK.
  - A parity flag with a stop bit of 1: pulse Rx_Err_Sig, discard the frame and go to IDLE.
  - Otherwise store the byte at Rx_Data slot [k*DATA_BITS +: DATA_BITS], with the first-received byte at k=0 (LSBs).
  - If k=BYTES_PER_FRAME-1, load Rx_Data and pulse Rx_Done_Sig together, one cycle after the stop decision, then go to IDLE. Otherwise increment k and go to GAP.
- GAP: a falling edge goes to START. If IDLE_BITS bit times of high elapse, pulse Rx_Err_Sig, reset k to 0 and go to IDLE.
- BREAK: wait for a synchronised 1, then go to IDLE.
- Rx_Data holds its value between Rx_Done_Sig pulses. Partial frames are never visible on Rx_Data.
- Rx_En_Sig deasserted in any non-IDLE state: return to IDLE within 1 cycle, k=0, no pulses.
- Collision: at every registered bit decision (start, data, parity, stop) with Tx_Active=1, a sample differing from Tx_Pin_Loopback pulses Tx_Cancel for one cycle. Reception continues unchanged. At most one Tx_Cancel per bit.
- Bus_Idle: a counter of high cycles is cleared by any synchronised 0. Bus_Idle is set when the counter reaches IDLE_BITS*CLKS_PER_BIT and cleared on the cycle the synchronised line goes 0. The counter saturates and does not wrap.
- Simultaneous events: Rx_Err_Sig and Rx_Done_Sig are never asserted together. Tx_Cancel may coincide with either.

Test Plan:
- CLKS_PER_BIT=16, defaults otherwise. Send bytes 0x11, 0x22, 0x33, 0x44 back-to-back → exactly one Start_Rx pulse, then Rx_Done_Sig with Rx_Data=0x44332211, and no Rx_Err_Sig.
- Apply a 5-cycle low glitch on an idle line → no Start_Rx, state back to IDLE, and Bus_Idle drops for the glitch then re-asserts 176 cycles after the line returns high.
- PARITY_EN=1, PARITY_ODD=0. Send 0x03 with parity bit 1 → one Rx_Err_Sig pulse, no Rx_Done_Sig, Rx_Data unchanged.
- Drive the stop bit low on byte 2, then hold the line low for 40 bit times → one Rx_Err_Sig, BREAK until the line rises, then a clean 4-byte frame 0xDEADBEEF is received correctly.
- Send 2 bytes, then hold the line high for 11 bit times → one Rx_Err_Sig (timeout). The next 4-byte frame 0x01020304 is received with k restarting at 0.
- Tx_Active=1 with Tx_Pin_Loopback tracking the line except a forced 0 on data bit 3 of the line → exactly one Tx_Cancel pulse at that bit's decision, and the frame still completes.

Source files
------------

// File: rtl/uart_frame_rx_module.sv
// Oversampling UART receiver that assembles BYTES_PER_FRAME characters into one
// frame word. It checks optional parity and the stop bit, tracks bus idle, aborts
// frames on inter-byte timeout and flags collisions against the local transmitter.
module uart_frame_rx_module #(
  parameter int unsigned CLKS_PER_BIT    = 434,
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned BYTES_PER_FRAME = 4,
  parameter int unsigned PARITY_EN       = 0,
  parameter int unsigned PARITY_ODD      = 0,
  parameter int unsigned IDLE_BITS       = 11
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 Rx_Pin_In,
  input  logic                                 Rx_En_Sig,
  input  logic                                 Tx_Active,
  input  logic                                 Tx_Pin_Loopback,
  output logic [DATA_BITS*BYTES_PER_FRAME-1:0] Rx_Data,
  output logic                                 Rx_Done_Sig,
  output logic                                 Rx_Err_Sig,
  output logic                                 Tx_Cancel,
  output logic                                 Start_Rx,
  output logic                                 Bus_Idle
);

  localparam int unsigned FRAME_W     = DATA_BITS * BYTES_PER_FRAME;
  localparam int unsigned CNT_W       = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDLE_CYCLES = IDLE_BITS * CLKS_PER_BIT;
  localparam int unsigned IDLE_W      = $clog2(IDLE_CYCLES + 1);

  localparam logic [CNT_W-1:0]  SAMPLE_A   = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_B   = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0]  SAMPLE_C   = CNT_W'(CLKS_PER_BIT / 2 + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_CYCLES);
  localparam logic [3:0]        LAST_BIT   = 4'(DATA_BITS - 1);
  localparam logic [3:0]        LAST_K     = 4'(BYTES_PER_FRAME - 1);
  localparam logic              ODD_PAR    = (PARITY_ODD != 0);
  localparam logic              HAS_PAR    = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    StIdle, StStart, StData, StParity, StStop, StGap, StBreak
  } state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [3:0]           k_q, k_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic [IDLE_W-1:0]    gap_q, gap_d;
  logic [IDLE_W-1:0]    idle_cnt_q, idle_cnt_d;
  logic                 bus_idle_q, bus_idle_d;
  logic [FRAME_W-1:0]   frame_q, frame_d, frame_ins;
  logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
  logic                 done_q, done_d, err_q, err_d;
  logic                 cancel_q, cancel_d, start_q, start_d;

  logic fall, maj, decide, bit_state, exp_par;

  assign fall      = rx_prev_q & ~rx_sync_q;
  assign maj       = (s0_q & s1_q) | (s0_q & rx_sync_q) | (s1_q & rx_sync_q);
  assign decide    = (cnt_q == SAMPLE_C);
  assign bit_state = (state_q == StStart) || (state_q == StData) ||
                     (state_q == StParity) || (state_q == StStop);
  assign exp_par   = (^shift_q) ^ ODD_PAR;

  // Current frame buffer with the just-completed character dropped into slot k.
  always_comb begin
    frame_ins = frame_q;
    for (int i = 0; i < int'(BYTES_PER_FRAME); i++) begin
      if (k_q == 4'(i)) frame_ins[i*DATA_BITS +: DATA_BITS] = shift_q;
    end
  end

  // Bus idle counter: saturating count of synchronised high cycles.
  always_comb begin
    if (!rx_sync_q) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == IDLE_LIMIT) begin
      idle_cnt_d = idle_cnt_q;
    end else begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
    bus_idle_d = rx_sync_q && (idle_cnt_d == IDLE_LIMIT);
  end

  // Receive FSM next-state, bit sampling and pulse generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    bit_idx_d = bit_idx_q;
    k_d       = k_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    gap_d     = gap_q;
    frame_d   = frame_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cancel_d  = 1'b0;
    start_d   = 1'b0;

    if (bit_state) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      if (cnt_q == SAMPLE_A) s0_d = rx_sync_q;
      if (cnt_q == SAMPLE_B) s1_d = rx_sync_q;
      // Reception is unaffected by a collision; the transmitter just gets told.
      if (decide && Tx_Active && (maj != Tx_Pin_Loopback)) cancel_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (Rx_En_Sig && fall) state_d = StStart;
      end
      StStart: begin
        if (decide) begin
          if (maj) begin
            state_d = (k_q == '0) ? StIdle : StGap;
            gap_d   = '0;
          end else begin
            state_d   = StData;
            bit_idx_d = '0;
            par_err_d = 1'b0;
            start_d   = (k_q == '0);
          end
        end
      end
      StData: begin
        if (decide) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_BIT) begin
            state_d = HAS_PAR ? StParity : StStop;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (decide) begin
          par_err_d = (maj != exp_par);
          state_d   = StStop;
        end
      end
      StStop: begin
        if (decide) begin
          if (!maj) begin
            err_d   = 1'b1;
            k_d     = '0;
            state_d = StBreak;
          end else if (par_err_q) begin
            err_d   = 1'b1;
            k_d     = '0;
            state_d = StIdle;
          end else begin
            frame_d = frame_ins;
            if (k_q == LAST_K) begin
              rx_data_d = frame_ins;
              done_d    = 1'b1;
              k_d       = '0;
              state_d   = StIdle;
            end else begin
              k_d     = k_q + 1'b1;
              gap_d   = '0;
              state_d = StGap;
            end
          end
        end
      end
      StGap: begin
        if (fall) begin
          state_d = StStart;
          cnt_d   = '0;
        end else if (gap_q == IDLE_LIMIT - 1'b1) begin
          err_d   = 1'b1;
          k_d     = '0;
          state_d = StIdle;
        end else begin
          gap_d = rx_sync_q ? gap_q + 1'b1 : '0;
        end
      end
      StBreak: begin
        if (rx_sync_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Disabling mid-frame silently abandons whatever was in flight.
    if (!Rx_En_Sig && (state_q != StIdle)) begin
      state_d   = StIdle;
      cnt_d     = '0;
      k_d       = '0;
      frame_d   = frame_q;
      rx_data_d = rx_data_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      cancel_d  = 1'b0;
      start_d   = 1'b0;
    end
  end

  // Synchroniser, FSM state and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= StIdle;
      cnt_q      <= '0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      bit_idx_q  <= '0;
      k_q        <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      gap_q      <= '0;
      idle_cnt_q <= '0;
      bus_idle_q <= 1'b0;
      frame_q    <= '0;
      rx_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cancel_q   <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      rx_meta_q  <= Rx_Pin_In;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      bit_idx_q  <= bit_idx_d;
      k_q        <= k_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      gap_q      <= gap_d;
      idle_cnt_q <= idle_cnt_d;
      bus_idle_q <= bus_idle_d;
      frame_q    <= frame_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cancel_q   <= cancel_d;
      start_q    <= start_d;
    end
  end

  assign Rx_Data     = rx_data_q;
  assign Rx_Done_Sig = done_q;
  assign Rx_Err_Sig  = err_q;
  assign Tx_Cancel   = cancel_q;
  assign Start_Rx    = start_q;
  assign Bus_Idle    = bus_idle_q;

endmodule

// File: tb/tb_uart_frame_rx_module.sv
// Directed bench for uart_frame_rx_module: two instances, one without parity and
// one with even parity, both at 16 clocks per bit.
module tb_uart_frame_rx_module;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx, rx_p, en, tx_active, loop;
  logic [31:0] rx_data, rx_data_p;
  logic        done, err, cancel, start_rx, bus_idle;
  logic        done_p, err_p, cancel_p, start_p, bus_idle_p;

  int tests = 0;
  int fails = 0;
  int start_cnt = 0, done_cnt = 0, err_cnt = 0, cancel_cnt = 0, both_cnt = 0;
  int done_p_cnt = 0, err_p_cnt = 0;

  always #5 clk = ~clk;

  uart_frame_rx_module #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(clk), .RST(rst), .Rx_Pin_In(rx), .Rx_En_Sig(en), .Tx_Active(tx_active),
    .Tx_Pin_Loopback(loop), .Rx_Data(rx_data), .Rx_Done_Sig(done), .Rx_Err_Sig(err),
    .Tx_Cancel(cancel), .Start_Rx(start_rx), .Bus_Idle(bus_idle)
  );

  uart_frame_rx_module #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0)) dut_p (
    .CLK(clk), .RST(rst), .Rx_Pin_In(rx_p), .Rx_En_Sig(en), .Tx_Active(1'b0),
    .Tx_Pin_Loopback(1'b1), .Rx_Data(rx_data_p), .Rx_Done_Sig(done_p),
    .Rx_Err_Sig(err_p), .Tx_Cancel(cancel_p), .Start_Rx(start_p), .Bus_Idle(bus_idle_p)
  );

  // Pulse counters for both instances.
  always @(posedge clk) begin
    if (start_rx) start_cnt++;
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (cancel) cancel_cnt++;
    if (done && err) both_cnt++;
    if (done_p) done_p_cnt++;
    if (err_p) err_p_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input bit sel, input logic v, input logic lb);
    if (sel) rx_p = v;
    else rx = v;
    loop = lb;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input bit sel, input logic [7:0] d, input bit use_par,
                           input logic par_bit, input logic stop, input int force_bit);
    drive_bit(sel, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, (i == force_bit) ? 1'b0 : d[i], d[i]);
    if (use_par) drive_bit(sel, par_bit, par_bit);
    drive_bit(sel, stop, stop);
    loop = 1'b1;
  endtask

  task automatic send_frame(input logic [31:0] f);
    for (int b = 0; b < 4; b++) send_byte(1'b0, f[b*8 +: 8], 1'b0, 1'b0, 1'b1, -1);
  endtask

  task automatic wait_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rx = 1'b1; rx_p = 1'b1; en = 1'b1; tx_active = 1'b0; loop = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rx_data", 64'(rx_data), 64'h0);
    check("reset_bus_idle", 64'(bus_idle), 64'h0);
    check("reset_done", 64'(done), 64'h0);
    check("reset_err", 64'(err), 64'h0);
    check("reset_cancel", 64'(cancel), 64'h0);
    check("reset_start", 64'(start_rx), 64'h0);
    rst = 1'b0;
    wait_bits(15);
    check("bus_idle_after_reset", 64'(bus_idle), 64'h1);

    // Back-to-back four-byte frame.
    send_frame(32'h44332211);
    wait_bits(3);
    check("t1_start_cnt", 64'(start_cnt), 64'd1);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_err_cnt", 64'(err_cnt), 64'd0);
    check("t1_data", 64'(rx_data), 64'h44332211);

    // Short glitch: false start, Bus_Idle drops then returns 176 cycles later.
    rx = 1'b0;
    repeat (5) @(negedge clk);
    check("t2_bus_idle_low", 64'(bus_idle), 64'h0);
    rx = 1'b1;
    repeat (170) @(negedge clk);
    check("t2_bus_idle_early", 64'(bus_idle), 64'h0);
    repeat (15) @(negedge clk);
    check("t2_bus_idle_back", 64'(bus_idle), 64'h1);
    check("t2_start_cnt", 64'(start_cnt), 64'd1);
    check("t2_err_cnt", 64'(err_cnt), 64'd0);

    // Even parity: 0x03 needs parity 0, send 1.
    send_byte(1'b1, 8'h03, 1'b1, 1'b1, 1'b1, -1);
    wait_bits(2);
    check("t3_err_p", 64'(err_p_cnt), 64'd1);
    check("t3_done_p", 64'(done_p_cnt), 64'd0);
    check("t3_data_p", 64'(rx_data_p), 64'h0);
    send_byte(1'b1, 8'h03, 1'b1, 1'b0, 1'b1, -1);
    send_byte(1'b1, 8'h01, 1'b1, 1'b1, 1'b1, -1);
    send_byte(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, -1);
    send_byte(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, -1);
    wait_bits(3);
    check("t3_done_p_good", 64'(done_p_cnt), 64'd1);
    check("t3_data_p_good", 64'(rx_data_p), 64'h00070103);
    check("t3_err_p_good", 64'(err_p_cnt), 64'd1);

    // Framing error on second byte, long break, then a clean frame.
    send_byte(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, -1);
    send_byte(1'b0, 8'h22, 1'b0, 1'b0, 1'b0, -1);
    wait_bits(40);
    check("t4_err_cnt", 64'(err_cnt), 64'd1);
    check("t4_data_held", 64'(rx_data), 64'h44332211);
    rx = 1'b1;
    wait_bits(2);
    send_frame(32'hDEADBEEF);
    wait_bits(3);
    check("t4_done_cnt", 64'(done_cnt), 64'd2);
    check("t4_data", 64'(rx_data), 64'hDEADBEEF);
    check("t4_err_after", 64'(err_cnt), 64'd1);
    check("t4_start_cnt", 64'(start_cnt), 64'd3);

    // Inter-byte timeout after two bytes, then a fresh frame.
    send_byte(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, -1);
    send_byte(1'b0, 8'h66, 1'b0, 1'b0, 1'b1, -1);
    wait_bits(13);
    check("t5_err_cnt", 64'(err_cnt), 64'd2);
    check("t5_done_hold", 64'(done_cnt), 64'd2);
    send_frame(32'h01020304);
    wait_bits(3);
    check("t5_done_cnt", 64'(done_cnt), 64'd3);
    check("t5_data", 64'(rx_data), 64'h01020304);

    // Collision on data bit 3 of the first byte.
    tx_active = 1'b1;
    send_byte(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 3);
    send_byte(1'b0, 8'h12, 1'b0, 1'b0, 1'b1, -1);
    send_byte(1'b0, 8'h34, 1'b0, 1'b0, 1'b1, -1);
    send_byte(1'b0, 8'h56, 1'b0, 1'b0, 1'b1, -1);
    wait_bits(3);
    tx_active = 1'b0;
    check("t6_cancel_cnt", 64'(cancel_cnt), 64'd1);
    check("t6_done_cnt", 64'(done_cnt), 64'd4);
    check("t6_data", 64'(rx_data), 64'h563412F7);
    check("t6_err_cnt", 64'(err_cnt), 64'd2);

    // Disable mid-frame: partial frame dropped, no pulses, k restarts.
    send_byte(1'b0, 8'h77, 1'b0, 1'b0, 1'b1, -1);
    send_byte(1'b0, 8'h88, 1'b0, 1'b0, 1'b1, -1);
    en = 1'b0;
    send_byte(1'b0, 8'h99, 1'b0, 1'b0, 1'b1, -1);
    send_byte(1'b0, 8'hAA, 1'b0, 1'b0, 1'b1, -1);
    wait_bits(1);
    en = 1'b1;
    wait_bits(15);
    check("t7_err_cnt", 64'(err_cnt), 64'd2);
    check("t7_done_cnt", 64'(done_cnt), 64'd4);
    check("t7_start_cnt", 64'(start_cnt), 64'd7);
    send_frame(32'h3CC35AA5);
    wait_bits(3);
    check("t7_data", 64'(rx_data), 64'h3CC35AA5);
    check("t7_done_after", 64'(done_cnt), 64'd5);
    check("done_err_overlap", 64'(both_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
